// File: rtl/stream_fifo.sv
// Synchronous single-clock stream FIFO with valid/ready handshakes on both sides.
// First-word fall-through read port, occupancy count, almost flags and a high-water mark.
module stream_fifo #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     s_valid,
    input  logic [WIDTH-1:0]         s_data,
    output logic                     s_ready,
    output logic                     m_valid,
    output logic [WIDTH-1:0]         m_data,
    input  logic                     m_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   high_water
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);
    localparam logic [CW-1:0] AF_LVL   = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_LVL   = CW'(AE_THRESH);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_nxt;
    logic [CW-1:0] high_water_q;
    logic [CW-1:0] high_water_nxt;

    logic push;
    logic pop;

    // Handshake flags depend on the registered count only, so a full FIFO
    // never accepts a write even when the head is popped in the same cycle.
    assign s_ready = (count_q != FULL_LVL);
    assign m_valid = (count_q != '0);

    assign push = s_valid && s_ready;
    assign pop  = m_valid && m_ready;

    assign m_data       = mem[rd_ptr];
    assign count        = count_q;
    assign high_water   = high_water_q;
    assign almost_full  = (count_q >= AF_LVL);
    assign almost_empty = (count_q <= AE_LVL);

    always_comb begin
        // NOTE: every variable written here gets a default first so no latch is inferred.
        count_nxt      = count_q;
        high_water_nxt = high_water_q;

        unique case ({push, pop})
            2'b10:   count_nxt = count_q + CW'(1);
            2'b01:   count_nxt = count_q - CW'(1);
            default: count_nxt = count_q;
        endcase

        if (flush) begin
            count_nxt      = '0;
            high_water_nxt = '0;
        end else if (count_nxt > high_water_q) begin
            high_water_nxt = count_nxt;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count_q      <= '0;
            high_water_q <= '0;
        end else if (flush) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count_q      <= '0;
            high_water_q <= '0;
        end else begin
            // Pointers are exactly PW bits wide, so wrap at DEPTH comes for free.
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            count_q      <= count_nxt;
            high_water_q <= high_water_nxt;
        end
    end

    // NOTE: the storage array has no reset; entries are only visible once count covers them.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= s_data;
        end
    end

endmodule

// File: tb/tb_stream_fifo.sv
// Directed bench for stream_fifo (WIDTH=8, DEPTH=4) with a queue-based reference model
// compared every cycle, plus literal expectations for the headline scenarios.
module tb_stream_fifo;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int AF    = DEPTH - 2;
    localparam int AE    = 2;

    logic             clk     = 1'b0;
    logic             rst     = 1'b1;
    logic             flush   = 1'b0;
    logic             s_valid = 1'b0;
    logic [WIDTH-1:0] s_data  = '0;
    logic             m_ready = 1'b0;
    logic             s_ready;
    logic             m_valid;
    logic [WIDTH-1:0] m_data;
    logic [2:0]       count;
    logic             almost_full;
    logic             almost_empty;
    logic [2:0]       high_water;

    stream_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .s_valid      (s_valid),
        .s_data       (s_data),
        .s_ready      (s_ready),
        .m_valid      (m_valid),
        .m_data       (m_data),
        .m_ready      (m_ready),
        .count        (count),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .high_water   (high_water)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Reference model: a plain queue of stored bytes plus the peak occupancy.
    byte unsigned mq[$];
    int           mhw = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            mhw = 0;
        end else if (flush) begin
            mq.delete();
            mhw = 0;
        end else begin
            automatic bit do_push = s_valid && (mq.size() < DEPTH);
            automatic bit do_pop  = m_ready && (mq.size() > 0);
            if (do_pop)  void'(mq.pop_front());
            if (do_push) mq.push_back(s_data);
            if (mq.size() > mhw) mhw = mq.size();
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("m_count",    32'(count),        32'(mq.size()));
            check("m_s_ready",  32'(s_ready),      32'(mq.size() != DEPTH));
            check("m_m_valid",  32'(m_valid),      32'(mq.size() != 0));
            check("m_af",       32'(almost_full),  32'(mq.size() >= AF));
            check("m_ae",       32'(almost_empty), 32'(mq.size() <= AE));
            check("m_hw",       32'(high_water),   32'(mhw));
            if (mq.size() != 0) check("m_data", 32'(m_data), 32'(mq[0]));
        end
    end

    task automatic step(input logic sv, input logic [7:0] sd, input logic mr, input logic fl);
        s_valid = sv;
        s_data  = sd;
        m_ready = mr;
        flush   = fl;
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        m_ready = 1'b0;
        flush   = 1'b0;
    endtask

    logic [7:0] fill_v [4];
    logic [7:0] refill_order [4];

    initial begin
        fill_v       = '{8'h11, 8'h22, 8'h33, 8'h44};
        refill_order = '{8'hA1, 8'hA2, 8'hA3, 8'hB0};

        // Reset state
        #2;
        check("rst_count", 32'(count),        32'd0);
        check("rst_s_rdy", 32'(s_ready),      32'd1);
        check("rst_m_vld", 32'(m_valid),      32'd0);
        check("rst_af",    32'(almost_full),  32'd0);
        check("rst_ae",    32'(almost_empty), 32'd1);
        check("rst_hw",    32'(high_water),   32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Fill
        step(1'b1, fill_v[0], 1'b0, 1'b0);
        check("lat_count", 32'(count),  32'd1);
        check("lat_vld",   32'(m_valid), 32'd1);
        check("lat_data",  32'(m_data),  32'h11);
        for (int i = 1; i < 4; i++) step(1'b1, fill_v[i], 1'b0, 1'b0);
        check("fill_count", 32'(count),        32'd4);
        check("fill_s_rdy", 32'(s_ready),      32'd0);
        check("fill_af",    32'(almost_full),  32'd1);
        check("fill_ae",    32'(almost_empty), 32'd0);
        check("fill_data",  32'(m_data),       32'h11);
        check("fill_hw",    32'(high_water),   32'd4);

        // Drain order
        for (int i = 0; i < 4; i++) begin
            check("drain_data", 32'(m_data), 32'(fill_v[i]));
            step(1'b0, 8'h00, 1'b1, 1'b0);
        end
        check("drain_vld",   32'(m_valid),    32'd0);
        check("drain_count", 32'(count),      32'd0);
        check("drain_hw",    32'(high_water), 32'd4);

        // Full with simultaneous push and pop
        for (int i = 0; i < 4; i++) step(1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0);
        step(1'b1, 8'hB0, 1'b1, 1'b0);
        check("fullsim_count", 32'(count),  32'd3);
        check("fullsim_data",  32'(m_data), 32'hA1);
        step(1'b1, 8'hB0, 1'b0, 1'b0);
        check("fullsim_count2", 32'(count), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check("fullsim_order", 32'(m_data), 32'(refill_order[i]));
            step(1'b0, 8'h00, 1'b1, 1'b0);
        end

        // Empty with simultaneous push and pop: no bypass
        step(1'b1, 8'h5A, 1'b1, 1'b0);
        check("empsim_count", 32'(count),  32'd1);
        check("empsim_vld",   32'(m_valid), 32'd1);
        check("empsim_data",  32'(m_data),  32'h5A);
        step(1'b0, 8'h00, 1'b1, 1'b0);

        // Wrap-around at steady occupancy of 2
        step(1'b1, 8'h01, 1'b0, 1'b0);
        step(1'b1, 8'h02, 1'b0, 1'b0);
        check("wrap_af", 32'(almost_full),  32'd1);
        check("wrap_ae", 32'(almost_empty), 32'd1);
        for (int i = 0; i < 10; i++) begin
            check("wrap_data", 32'(m_data), 32'(i + 1));
            step(1'b1, 8'(i + 3), 1'b1, 1'b0);
        end
        check("wrap_count", 32'(count),  32'd2);
        check("wrap_tail",  32'(m_data), 32'h0B);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);

        // Flush overrides a concurrent push
        for (int i = 0; i < 3; i++) step(1'b1, 8'h71 + 8'(i), 1'b0, 1'b0);
        check("pre_flush_count", 32'(count), 32'd3);
        step(1'b1, 8'h99, 1'b1, 1'b1);
        check("flush_count", 32'(count),      32'd0);
        check("flush_hw",    32'(high_water), 32'd0);
        check("flush_vld",   32'(m_valid),    32'd0);

        // Asynchronous reset mid-cycle
        for (int i = 0; i < 3; i++) step(1'b1, 8'h81 + 8'(i), 1'b0, 1'b0);
        check("pre_rst_count", 32'(count), 32'd3);
        #2;
        rst = 1'b1;
        #1;
        check("arst_count", 32'(count),      32'd0);
        check("arst_hw",    32'(high_water), 32'd0);
        check("arst_vld",   32'(m_valid),    32'd0);
        check("arst_s_rdy", 32'(s_ready),    32'd1);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        step(1'b1, 8'hC3, 1'b0, 1'b0);
        check("post_rst_data", 32'(m_data), 32'hC3);
        step(1'b0, 8'h00, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
